// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the audio output chain
`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif

package audio_pkg;

    localparam int WIDTH       = 24;
    localparam int FIXED_POINT = `FIXED_POINT;
    localparam int WORD        = WIDTH + FIXED_POINT;
    localparam int SAMPLE_BITS = 24;

    typedef logic signed [SAMPLE_BITS-1:0] sample_t;
    typedef logic signed [WORD-1:0]        fixed_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } out_state_t;

    localparam sample_t SAT_MAX = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
    localparam sample_t SAT_MIN = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

endpackage

// File: rtl/sample_saturator.sv
// rtl/sample_saturator.sv - master volume multiply, floor shift and clamp to DAC width
module sample_saturator
    import audio_pkg::*;
(
    input  logic [WORD-1:0]        sample_in,
    input  logic [WORD-1:0]        gain,
    output logic [SAMPLE_BITS-1:0] sample_out,
    output logic                   clip
);

    localparam int PW = 2 * WORD;
    localparam logic signed [PW-1:0] V_MAX = {{(PW-SAMPLE_BITS){SAT_MAX[SAMPLE_BITS-1]}}, SAT_MAX};
    localparam logic signed [PW-1:0] V_MIN = {{(PW-SAMPLE_BITS){SAT_MIN[SAMPLE_BITS-1]}}, SAT_MIN};

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] g_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] v;

    always_comb begin
        a_ext      = {{WORD{sample_in[WORD-1]}}, sample_in};
        g_ext      = {{WORD{gain[WORD-1]}}, gain};
        prod       = a_ext * g_ext;
        // Both operands carry FIXED_POINT fraction bits; arithmetic shift floors toward -inf.
        v          = prod >>> (2 * FIXED_POINT);
        sample_out = v[SAMPLE_BITS-1:0];
        clip       = 1'b0;
        if (v > V_MAX) begin
            sample_out = SAT_MAX;
            clip       = 1'b1;
        end else if (v < V_MIN) begin
            sample_out = SAT_MIN;
            clip       = 1'b1;
        end
    end

endmodule

// File: rtl/master_output_stage.sv
// rtl/master_output_stage.sv - master volume, 1-entry sample buffer and I2S serialiser to the DAC
module master_output_stage
    import audio_pkg::*;
#(
    parameter int SLOT_BITS = 32,
    parameter int BCLK_DIV  = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            enable,
    input  logic            sample_valid,
    input  logic [WORD-1:0] in,
    input  logic [WORD-1:0] volume,
    input  logic            status_clr,
    output logic            dac_bclk,
    output logic            dac_lrclk,
    output logic            dac_sdata,
    output logic            clip,
    output logic            overrun,
    output logic            underrun
);

    localparam int CNT_W = $clog2(2 * SLOT_BITS);
    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] SLOT     = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0] POS_LAST = CNT_W'(SAMPLE_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    out_state_t state;
    out_state_t state_nxt;

    logic [DIV_W-1:0]       div;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic [CNT_W-1:0]       pos_next;
    logic [SAMPLE_BITS-1:0] sat_sample;
    logic                   sat_clip;
    logic [SAMPLE_BITS-1:0] smp_buf;
    logic                   buf_full;
    logic [SAMPLE_BITS-1:0] frame;
    logic [SAMPLE_BITS-1:0] shreg;

    logic active;
    logic div_wrap;
    logic bclk_fall;
    logic frame_wrap;
    logic start;
    logic load;
    logic overrun_set;
    logic underrun_set;

    sample_saturator u_sat (
        .sample_in  (in),
        .gain       (volume),
        .sample_out (sat_sample),
        .clip       (sat_clip)
    );

    always_comb begin
        active       = (state != IDLE);
        div_wrap     = (div == DIV_LAST);
        bclk_fall    = active && div_wrap && dac_bclk;
        cnt_next     = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
        pos_next     = (cnt_next >= SLOT) ? cnt_next - SLOT : cnt_next;
        frame_wrap   = bclk_fall && (bit_cnt == CNT_LAST);
        start        = (state == IDLE) && enable && buf_full;
        // A wrap seen with enable low ends the stream instead of loading another frame.
        load         = start || ((state == RUN) && frame_wrap && enable);
        overrun_set  = sample_valid && buf_full && !load;
        underrun_set = load && !buf_full;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (!enable) state_nxt = frame_wrap ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (frame_wrap) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The load reads the old buffer; a coincident capture refills it for the next frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            smp_buf  <= '0;
            buf_full <= 1'b0;
            frame    <= '0;
        end else begin
            if (load && buf_full) frame <= smp_buf;
            if (sample_valid) begin
                smp_buf  <= sat_sample;
                buf_full <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div       <= '0;
            bit_cnt   <= '0;
            dac_bclk  <= 1'b0;
            dac_lrclk <= 1'b0;
            dac_sdata <= 1'b0;
            shreg     <= '0;
        end else if (!active || state_nxt == IDLE) begin
            div       <= '0;
            bit_cnt   <= '0;
            dac_bclk  <= 1'b0;
            dac_lrclk <= 1'b0;
            dac_sdata <= 1'b0;
        end else begin
            div <= div_wrap ? '0 : div + 1'b1;
            if (div_wrap) dac_bclk <= ~dac_bclk;
            if (bclk_fall) begin
                bit_cnt   <= cnt_next;
                dac_lrclk <= (cnt_next >= SLOT);
                // Slot position 0 is the I2S one-bit delay after the lrclk edge.
                if (pos_next == CNT_W'(1)) begin
                    dac_sdata <= frame[SAMPLE_BITS-1];
                    shreg     <= frame << 1;
                end else if (pos_next >= CNT_W'(2) && pos_next <= POS_LAST) begin
                    dac_sdata <= shreg[SAMPLE_BITS-1];
                    shreg     <= shreg << 1;
                end else begin
                    dac_sdata <= 1'b0;
                end
            end
        end
    end

    // A set event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clip     <= 1'b0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            clip     <= (sample_valid && sat_clip) || (clip && !status_clr);
            overrun  <= overrun_set || (overrun && !status_clr);
            underrun <= underrun_set || (underrun && !status_clr);
        end
    end

endmodule
